crc9_par3_ctrl: RTL and testbench

Sequencer for the 3-bit-per-cycle CRC datapath on generator g(y) = y^9 + y^8 + y + 1. Accepts a start command with a message length in 3-bit symbols, pulls symbols over a valid/ready stream, and folds each symbol into a 9-bit remainder, three bits per clock. It then presents the final remainder on a valid/ready result port. It sits between the message source and the CRC consumer and replaces free-running shift-and-display operation with framed, handshaked transactions.

---
 rtl/crc9_par3_ctrl.sv | 138 +++++++++++++
 tb/tb_crc9_par3_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc9_par3_ctrl.sv
// Framed, handshaked sequencer for the 3-bit-per-cycle CRC on g(y) = y^9 + y^8 + y + 1.
// Accepts a start/length command, folds one 3-bit symbol per cycle and presents the remainder.
module crc9_par3_ctrl #(
  parameter logic [8:0] INIT = 9'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_msg_len,
  input  logic       i_abort,
  input  logic       i_in_valid,
  input  logic [2:0] i_in_data,
  output logic       o_in_ready,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [8:0] o_crc_out,
  output logic       o_busy,
  output logic [7:0] o_sym_left
);

  localparam logic [8:0] POLY = 9'h103;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [8:0] r_crc;
  logic [7:0] r_sym_left;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       r_busy;
  logic [8:0] w_crc_next;

  function automatic logic [8:0] crc_step1(input logic [8:0] crc, input logic b);
    logic fb;
    fb = crc[8] ^ b;
    return {crc[7:0], 1'b0} ^ (fb ? POLY : 9'h000);
  endfunction

  // Message order is MSB first: in_data[2] enters the remainder before in_data[0].
  function automatic logic [8:0] crc_step3(input logic [8:0] crc, input logic [2:0] sym);
    logic [8:0] c;
    c = crc_step1(crc, sym[2]);
    c = crc_step1(c, sym[1]);
    c = crc_step1(c, sym[0]);
    return c;
  endfunction

  // Unrolled fold of the current input symbol into the remainder.
  always_comb begin
    w_crc_next = crc_step3(r_crc, i_in_data);
  end

  // Sequencer: state, remainder, symbol counter and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_crc       <= 9'h000;
      r_sym_left  <= 8'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_abort) begin
      r_state     <= IDLE;
      r_sym_left  <= 8'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_crc      <= INIT;
            r_sym_left <= i_msg_len;
            r_busy     <= 1'b1;
            if (i_msg_len == 8'd0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state     <= RUN;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end else begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        RUN: begin
          if (i_in_valid && r_in_ready) begin
            r_crc <= w_crc_next;
            // Counter saturates at zero; the last accept moves straight to DONE.
            if (r_sym_left <= 8'd1) begin
              r_sym_left  <= 8'd0;
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_sym_left <= r_sym_left - 8'd1;
              r_state    <= RUN;
            end
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sym_left  <= 8'd0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_crc_out   = r_crc;
  assign o_busy      = r_busy;
  assign o_sym_left  = r_sym_left;

endmodule

// File: tb/tb_crc9_par3_ctrl.sv
// Directed bench for crc9_par3_ctrl; expected remainders hand-computed from the serial step.
module tb_crc9_par3_ctrl;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [7:0] i_msg_len;
  logic       i_abort;
  logic       i_in_valid;
  logic [2:0] i_in_data;
  logic       o_in_ready;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [8:0] o_crc_out;
  logic       o_busy;
  logic [7:0] o_sym_left;

  int n_total;
  int n_bad;

  crc9_par3_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_msg_len  (i_msg_len),
    .i_abort    (i_abort),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_in_ready (o_in_ready),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_crc_out  (o_crc_out),
    .o_busy     (o_busy),
    .o_sym_left (o_sym_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, o_busy, 1'b0);
    check({tag, ".in_ready"}, o_in_ready, 1'b0);
    check({tag, ".out_valid"}, o_out_valid, 1'b0);
    check({tag, ".sym_left"}, o_sym_left, 8'd0);
  endtask

  task automatic do_start(input logic [7:0] len);
    i_start = 1'b1;
    i_msg_len = len;
    step();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [2:0] sym);
    i_in_valid = 1'b1;
    i_in_data = sym;
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic finish_result(input string tag);
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    reset = 1'b1;
    i_start = 1'b0;
    i_msg_len = 8'd0;
    i_abort = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = 3'b000;
    i_out_ready = 1'b0;
    step();
    check("rst.crc", o_crc_out, 9'h000);
    check_idle("rst");
    reset = 1'b0;
    step();
    check_idle("rel");

    // Single symbol 001 -> 103
    do_start(8'd1);
    check("s1.in_ready", o_in_ready, 1'b1);
    check("s1.busy", o_busy, 1'b1);
    check("s1.sym_left", o_sym_left, 8'd1);
    check("s1.ov_early", o_out_valid, 1'b0);
    send(3'b001);
    check("s1.out_valid", o_out_valid, 1'b1);
    check("s1.crc", o_crc_out, 9'h103);
    check("s1.in_ready_done", o_in_ready, 1'b0);
    check("s1.sym_left_done", o_sym_left, 8'd0);
    finish_result("s1.end");

    // Single symbol 100 -> 109
    do_start(8'd1);
    send(3'b100);
    check("s2.out_valid", o_out_valid, 1'b1);
    check("s2.crc", o_crc_out, 9'h109);
    finish_result("s2.end");

    // Two symbols back-to-back 001,000 -> 111
    do_start(8'd2);
    check("b2b.sym_left0", o_sym_left, 8'd2);
    send(3'b001);
    check("b2b.sym_left1", o_sym_left, 8'd1);
    check("b2b.ov_mid", o_out_valid, 1'b0);
    send(3'b000);
    check("b2b.out_valid", o_out_valid, 1'b1);
    check("b2b.crc", o_crc_out, 9'h111);
    finish_result("b2b.end");

    // Same with two stall cycles between symbols
    do_start(8'd2);
    send(3'b001);
    for (int k = 0; k < 2; k++) begin
      i_in_data = 3'b111;
      step();
      check("gap.stall_ov", o_out_valid, 1'b0);
      check("gap.stall_left", o_sym_left, 8'd1);
      check("gap.stall_crc", o_crc_out, 9'h103);
    end
    send(3'b000);
    check("gap.out_valid", o_out_valid, 1'b1);
    check("gap.crc", o_crc_out, 9'h111);
    finish_result("gap.end");

    // Zero length
    do_start(8'd0);
    check("z.out_valid", o_out_valid, 1'b1);
    check("z.crc", o_crc_out, 9'h000);
    check("z.in_ready", o_in_ready, 1'b0);
    check("z.busy", o_busy, 1'b1);
    finish_result("z.end");

    // Result back-pressure with an ignored start in DONE
    do_start(8'd1);
    send(3'b001);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        i_start = 1'b1;
        i_msg_len = 8'd5;
      end else begin
        i_start = 1'b0;
      end
      check("bp.out_valid", o_out_valid, 1'b1);
      check("bp.crc", o_crc_out, 9'h103);
      step();
    end
    check("bp.sym_left", o_sym_left, 8'd0);
    check("bp.in_ready", o_in_ready, 1'b0);
    i_start = 1'b1;
    i_msg_len = 8'd3;
    i_out_ready = 1'b1;
    step();
    i_start = 1'b0;
    i_out_ready = 1'b0;
    check_idle("bp.hs");
    step();
    check_idle("bp.after");

    // Abort after two of four symbols; simultaneous symbol not folded
    do_start(8'd4);
    send(3'b001);
    send(3'b010);
    check("ab.sym_left", o_sym_left, 8'd2);
    i_abort = 1'b1;
    i_in_valid = 1'b1;
    i_in_data = 3'b111;
    step();
    i_abort = 1'b0;
    i_in_valid = 1'b0;
    check_idle("ab");
    check("ab.crc_kept", o_crc_out, 9'h014);
    step();
    check("ab.no_ov", o_out_valid, 1'b0);
    do_start(8'd1);
    send(3'b001);
    check("ab.new_ov", o_out_valid, 1'b1);
    check("ab.new_crc", o_crc_out, 9'h103);
    finish_result("ab.end");

    // Asynchronous reset mid-message
    do_start(8'd4);
    send(3'b001);
    send(3'b010);
    #2;
    reset = 1'b1;
    #1;
    check("ar.crc", o_crc_out, 9'h000);
    check_idle("ar");
    @(negedge clk);
    reset = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 3'b001;
    step();
    i_in_valid = 1'b0;
    check_idle("ar.after");
    check("ar.crc_after", o_crc_out, 9'h000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
